apb_mem_slave: RTL and testbench

APB_MEM_SLAVE -- requirements
Module: apb_mem_slave

---
 rtl/apb_pkg.sv | 12 +
 rtl/apb_byte_ram.sv | 30 +++
 rtl/apb_mem_slave.sv | 131 +++++++++++++
 tb/tb_apb_mem_slave.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB memory slave: FSM state encoding and wait-counter sizing.
package apb_pkg;

  localparam int unsigned MAX_WAIT_CYCLES = 15;
  localparam int unsigned CNT_W           = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

endpackage

// File: rtl/apb_byte_ram.sv
// Word-organised storage with per-byte write enables, synchronous write and combinational read.
// Contents are deliberately not reset.
module apb_byte_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned AW     = 8
) (
  input  logic                clk_i,
  input  logic [DATA_W/8-1:0] we_i,
  input  logic [AW-1:0]       addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W-1:0]   rdata_o
);

  localparam int unsigned NB = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Byte-lane write port
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NB; b++) begin
      if (we_i[b]) begin
        mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/apb_mem_slave.sv
// APB slave backed by a byte-writable RAM, with a programmable number of wait states
// per access phase and an error response for word indices beyond the memory depth.
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                pclk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr
);

  localparam int unsigned NB         = DATA_W / 8;
  localparam int unsigned BYTE_SHIFT = $clog2(NB);
  localparam int unsigned RAM_AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WAIT_EFF   = (WAIT_CYCLES > MAX_WAIT_CYCLES) ? MAX_WAIT_CYCLES : WAIT_CYCLES;

  localparam logic [CNT_W-1:0]  WAIT_LOAD       = CNT_W'(WAIT_EFF);
  localparam logic [CNT_W-1:0]  CNT_ZERO        = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE         = CNT_W'(1);
  localparam logic              PREADY_AT_SETUP = (WAIT_EFF == 32'd0);
  localparam logic [ADDR_W:0]   DEPTH_LIM       = (ADDR_W + 1)'(DEPTH);

  apb_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;

  logic [ADDR_W-1:0]   word_idx_s;
  logic                addr_err_s;
  logic                complete_s;
  logic [NB-1:0]       ram_we_s;
  logic [DATA_W-1:0]   ram_rdata_s;

  assign word_idx_s = paddr >> BYTE_SHIFT;
  assign addr_err_s = ({1'b0, word_idx_s} >= DEPTH_LIM);
  assign ram_we_s   = pstrb & {NB{complete_s & pwrite & ~addr_err_s}};

  apb_byte_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (RAM_AW)
  ) u_ram (
    .clk_i   (pclk),
    .we_i    (ram_we_s),
    .addr_i  (word_idx_s[RAM_AW-1:0]),
    .wdata_i (pwdata),
    .rdata_o (ram_rdata_s)
  );

  // State, wait counter and registered response outputs
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= CNT_ZERO;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= {DATA_W{1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // Next-state, wait countdown and response computation
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pready_d   = pready_q;
    complete_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (psel && !penable) begin
          state_d  = ST_ACCESS;
          cnt_d    = WAIT_LOAD;
          pready_d = PREADY_AT_SETUP;
        end else begin
          cnt_d    = CNT_ZERO;
          pready_d = 1'b0;
        end
      end
      ST_ACCESS: begin
        if (!psel) begin
          state_d  = ST_IDLE;
          cnt_d    = CNT_ZERO;
          pready_d = 1'b0;
        end else if (penable && pready_q) begin
          complete_s = 1'b1;
          state_d    = ST_IDLE;
          cnt_d      = CNT_ZERO;
          pready_d   = 1'b0;
        end else if (cnt_q != CNT_ZERO) begin
          cnt_d    = cnt_q - CNT_ONE;
          pready_d = (cnt_q == CNT_ONE);
        end else begin
          pready_d = pready_q;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        cnt_d    = CNT_ZERO;
        pready_d = 1'b0;
      end
    endcase

    // Response fields are only meaningful alongside pready and are zero otherwise.
    pslverr_d = pready_d & addr_err_s;
    prdata_d  = (pready_d && !pwrite && !addr_err_s) ? ram_rdata_s : {DATA_W{1'b0}};
  end

  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign prdata  = prdata_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Randomised self-checking bench: two slaves (0 and 3 wait states) on a shared bus,
// checked against a word/byte-level memory model with per-byte "written" tracking.
module tb_apb_mem_slave;

  localparam int W0    = 0;
  localparam int W1    = 3;
  localparam int DEPTH = 256;

  logic        pclk = 1'b0;
  logic        rst_n;
  logic [31:0] paddr, pwdata;
  logic [1:0]  psel_v;
  logic        penable, pwrite;
  logic [3:0]  pstrb;
  logic [31:0] prdata0, prdata1;
  logic        pready0, pready1, pslverr0, pslverr1;

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc = 0;

  logic [31:0] mem_m   [2][DEPTH];
  logic [3:0]  known_m [2][DEPTH];

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  apb_mem_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(W0)) u_dut0 (
    .pclk(pclk), .rst_n(rst_n), .paddr(paddr), .psel(psel_v[0]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata0), .pready(pready0), .pslverr(pslverr0));

  apb_mem_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(W1)) u_dut1 (
    .pclk(pclk), .rst_n(rst_n), .paddr(paddr), .psel(psel_v[1]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata1), .pready(pready1), .pslverr(pslverr1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? pready0 : pready1;
  endfunction

  function automatic int exp_wait(input int d);
    return (d == 0) ? W0 : W1;
  endfunction

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic outs_zero(input string tag);
    check({tag, "_prdata0"},  prdata0,  32'h0);
    check({tag, "_pready0"},  {31'b0, pready0},  32'h0);
    check({tag, "_pslverr0"}, {31'b0, pslverr0}, 32'h0);
    check({tag, "_prdata1"},  prdata1,  32'h0);
    check({tag, "_pready1"},  {31'b0, pready1},  32'h0);
    check({tag, "_pslverr1"}, {31'b0, pslverr1}, 32'h0);
  endtask

  // One complete transfer; returns immediately after the completing edge so calls chain back-to-back.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, output logic [31:0] rd, output logic er);
    int waits;
    logic to;
    psel_v = 2'b00;
    psel_v[d] = 1'b1;
    penable = 1'b0;
    pwrite = wr;
    paddr = addr;
    pwdata = wdata;
    pstrb = strb;
    tick();
    penable = 1'b1;
    waits = 0;
    to = 1'b0;
    while (rdy(d) !== 1'b1 && !to) begin
      waits++;
      if (waits > 40) to = 1'b1;
      else tick();
    end
    check("timeout", {31'b0, to}, 32'h0);
    check("wait_states", waits, exp_wait(d));
    rd = (d == 0) ? prdata0 : prdata1;
    er = (d == 0) ? pslverr0 : pslverr1;
    tick();
    check("pready_drop", {31'b0, rdy(d)}, 32'h0);
    psel_v = 2'b00;
    penable = 1'b0;
  endtask

  // Transfer checked against the reference memory model.
  task automatic op(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                    input logic [3:0] strb);
    logic [31:0] rd, mask, idx;
    logic er, exp_err;
    xfer(d, wr, addr, wdata, strb, rd, er);
    idx = addr / 4;
    exp_err = (idx >= DEPTH);
    check(wr ? "wr_pslverr" : "rd_pslverr", {31'b0, er}, {31'b0, exp_err});
    if (wr) begin
      if (!exp_err) begin
        for (int b = 0; b < 4; b++) begin
          if (strb[b]) begin
            mem_m[d][idx][b*8 +: 8] = wdata[b*8 +: 8];
            known_m[d][idx][b] = 1'b1;
          end
        end
      end
    end else if (exp_err) begin
      check("rd_err_prdata", rd, 32'h0);
    end else begin
      for (int b = 0; b < 4; b++) mask[b*8 +: 8] = {8{known_m[d][idx][b]}};
      check("rd_prdata", rd & mask, mem_m[d][idx] & mask);
    end
  endtask

  initial begin
    logic [31:0] rd, wd, a;
    logic er;
    int pulses, d;
    int unsigned t0;

    for (int i = 0; i < 2; i++)
      for (int j = 0; j < DEPTH; j++) begin
        known_m[i][j] = 4'h0;
        mem_m[i][j] = 32'h0;
      end
    rst_n = 1'b0; psel_v = 2'b00; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0; pstrb = 4'h0;
    #1;
    outs_zero("reset");
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Basic write/read on both wait-state settings
    for (int k = 0; k < 2; k++) begin
      op(k, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      xfer(k, 1'b0, 32'h10, 32'h0, 4'h0, rd, er);
      check("deadbeef", rd, 32'hDEADBEEF);
      check("deadbeef_err", {31'b0, er}, 32'h0);
      tick();
    end

    // Partial-strobe merge
    for (int k = 0; k < 2; k++) begin
      op(k, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF);
      op(k, 1'b1, 32'h20, 32'h00000000, 4'h5);
      op(k, 1'b1, 32'h20, 32'h12345678, 4'h0);
      xfer(k, 1'b0, 32'h20, 32'h0, 4'h0, rd, er);
      check("strb_merge", rd, 32'hFF00FF00);
    end

    // Out-of-range access: error response, and word 0 (aliased low bits) untouched
    for (int k = 0; k < 2; k++) begin
      op(k, 1'b1, 32'h0, 32'h0BADF00D, 4'hF);
      op(k, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF);
      op(k, 1'b0, 32'h400, 32'h0, 4'h0);
      op(k, 1'b0, 32'h0, 32'h0, 4'h0);
    end

    // Abort by dropping psel during wait states
    op(1, 1'b1, 32'h34, 32'h55667788, 4'hF);
    psel_v = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 32'h34; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    tick();
    penable = 1'b1;
    tick();
    psel_v = 2'b00; penable = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (pready1 === 1'b1) pulses++;
      tick();
    end
    check("abort_pulses", pulses, 0);
    op(1, 1'b0, 32'h34, 32'h0, 4'h0);

    // Reset during the access phase of a write
    op(0, 1'b1, 32'h30, 32'h11223344, 4'hF);
    psel_v = 2'b01; penable = 1'b0; pwrite = 1'b1; paddr = 32'h30; pwdata = 32'hA5A5A5A5; pstrb = 4'hF;
    tick();
    penable = 1'b1;
    check("rst_pre_pready", {31'b0, pready0}, 32'h1);
    rst_n = 1'b0;
    #1;
    outs_zero("midrst");
    tick();
    psel_v = 2'b00; penable = 1'b0;
    rst_n = 1'b1;
    tick();
    op(0, 1'b0, 32'h30, 32'h0, 4'h0);

    // Back-to-back: four writes then four reads with no idle cycles
    for (int k = 0; k < 2; k++) begin
      t0 = cyc;
      for (int i = 0; i < 4; i++) op(k, 1'b1, 32'(i * 4), $urandom, 4'hF);
      for (int i = 0; i < 4; i++) op(k, 1'b0, 32'(i * 4), 32'h0, 4'h0);
      check("b2b_cycles", cyc - t0, 8 * (exp_wait(k) + 2));
      tick();
    end

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      d = $urandom_range(0, 1);
      a = ($urandom_range(0, 299) << 2) | $urandom_range(0, 3);
      wd = $urandom;
      op(d, $urandom_range(0, 1) == 1, a, wd, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) begin
        tick();
        check("idle_prdata0", prdata0, 32'h0);
        check("idle_prdata1", prdata1, 32'h0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
